// File: rtl/crt_pix_serializer_if.sv
// Bus between the CRT shift-load generator / plane fetch and the pixel serializer.
// The master side drives fetch data and strobes; the serializer (slave) returns pixels.
interface crt_pix_serializer_if;
  logic        dclk_en;
  logic        pre_load;
  logic        final_sh_ld;
  logic [31:0] m_plane_data;
  logic        c_9dot;
  logic        line_gfx_en;
  logic        c_lg_char;
  logic [1:0]  shift_mode;
  logic        screen_off;
  logic [3:0]  pix_out;
  logic        pix_vld;

  modport master (
    output dclk_en, pre_load, final_sh_ld, m_plane_data, c_9dot,
           line_gfx_en, c_lg_char, shift_mode, screen_off,
    input  pix_out, pix_vld
  );

  modport slave (
    input  dclk_en, pre_load, final_sh_ld, m_plane_data, c_9dot,
           line_gfx_en, c_lg_char, shift_mode, screen_off,
    output pix_out, pix_vld
  );
endinterface

// File: rtl/crt_pix_serializer.sv
// Captures four-plane fetches and serializes them into 4-bit pixel indices
// in planar, interleaved or packed order, with the optional 9th text dot.
module crt_pix_serializer (
  input logic                 t_crt_clk,
  input logic                 h_reset_n,
  crt_pix_serializer_if.slave bus
);

  logic [31:0] hold;
  logic        hold_lg;
  logic [7:0]  p0, p1, p2, p3;
  logic [1:0]  mode_l;
  logic        nine_l;
  logic        lg_l;
  logic [3:0]  dot_cnt;
  logic [3:0]  last_pix;
  logic [3:0]  pix_q;
  logic        vld_q;

  logic        load;
  logic        nine_eff;
  logic [31:0] src;
  logic [1:0]  src_mode;
  logic [15:0] lo, hi;
  logic [31:0] pk;
  logic [3:0]  step_pix;
  logic [31:0] step_next;

  assign load     = bus.final_sh_ld;
  assign nine_eff = nine_l & (mode_l == 2'b00);

  // A load emits dot 0 straight from hold, so the shift registers always hold
  // the remaining dots with the next one at the top.
  always_comb begin
    src       = load ? hold : {p3, p2, p1, p0};
    src_mode  = load ? bus.shift_mode : mode_l;
    lo        = {src[7:0], src[15:8]};
    hi        = {src[23:16], src[31:24]};
    pk        = {src[7:0], src[15:8], src[23:16], src[31:24]};
    step_pix  = 4'h0;
    step_next = 32'h0;
    case (src_mode)
      2'b00: begin
        step_pix  = {src[31], src[23], src[15], src[7]};
        step_next = {src[30:24], 1'b0, src[22:16], 1'b0,
                     src[14:8], 1'b0, src[6:0], 1'b0};
      end
      2'b01: begin
        step_pix  = {hi[15:14], lo[15:14]};
        step_next = {hi[5:0], 2'b00, hi[13:6], lo[5:0], 2'b00, lo[13:6]};
      end
      default: begin
        step_pix  = pk[31:28];
        step_next = {pk[3:0], 4'h0, pk[11:4], pk[19:12], pk[27:20]};
      end
    endcase
  end

  always_ff @(posedge t_crt_clk) begin
    if (!h_reset_n) begin
      hold     <= 32'h0;
      hold_lg  <= 1'b0;
      p0       <= 8'h0;
      p1       <= 8'h0;
      p2       <= 8'h0;
      p3       <= 8'h0;
      mode_l   <= 2'b00;
      nine_l   <= 1'b0;
      lg_l     <= 1'b0;
      dot_cnt  <= 4'd0;
      last_pix <= 4'h0;
      pix_q    <= 4'h0;
      vld_q    <= 1'b0;
    end else if (bus.dclk_en) begin
      if (bus.pre_load) begin
        hold    <= bus.m_plane_data;
        hold_lg <= bus.line_gfx_en & bus.c_lg_char;
      end
      {p3, p2, p1, p0} <= step_next;
      if (load) begin
        mode_l  <= bus.shift_mode;
        nine_l  <= bus.c_9dot;
        lg_l    <= hold_lg;
        dot_cnt <= 4'd1;
        pix_q   <= bus.screen_off ? 4'h0 : step_pix;
        vld_q   <= ~bus.screen_off;
      end else begin
        if (dot_cnt == 4'd7)
          last_pix <= step_pix;
        // dot_cnt 0 means nothing loaded since reset
        if (dot_cnt >= 4'd1 && dot_cnt <= 4'd7) begin
          pix_q <= bus.screen_off ? 4'h0 : step_pix;
          vld_q <= ~bus.screen_off;
        end else if (dot_cnt == 4'd8 && nine_eff) begin
          pix_q <= (bus.screen_off || !lg_l) ? 4'h0 : last_pix;
          vld_q <= ~bus.screen_off;
        end else begin
          pix_q <= 4'h0;
          vld_q <= 1'b0;
        end
        if (dot_cnt != 4'd0 && dot_cnt != 4'd9)
          dot_cnt <= dot_cnt + 4'd1;
      end
    end
  end

  assign bus.pix_out = pix_q;
  assign bus.pix_vld = vld_q;

endmodule

// File: tb/tb_crt_pix_serializer.sv
// Bench for crt_pix_serializer: directed test-plan characters plus a random
// strobe/data run, all checked against a per-character dot-list model.
module tb_crt_pix_serializer;

  logic t_crt_clk = 1'b0;
  logic h_reset_n;

  crt_pix_serializer_if bus ();

  crt_pix_serializer dut (
    .t_crt_clk (t_crt_clk),
    .h_reset_n (h_reset_n),
    .bus       (bus)
  );

  always #5 t_crt_clk = ~t_crt_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_hold;
  logic        m_hold_lg;
  logic [3:0]  m_dots [0:8];
  int          m_len;
  int          m_idx;
  logic [3:0]  m_pix;
  logic        m_vld;

  logic [3:0]  obs_pix;
  logic        obs_vld;

  logic [3:0] exp_planar [0:7] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1};
  logic [3:0] exp_packed [0:7] = '{4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'h4, 4'h7, 4'h6};
  logic [3:0] exp_inter  [0:7] = '{4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Dot list of one character, straight from the ordering rules.
  task automatic build_char(input logic [31:0] h, input logic [1:0] mode,
                            input logic nine, input logic lg);
    logic [15:0] lo, hi;
    logic [31:0] w;
    lo = {h[7:0], h[15:8]};
    hi = {h[23:16], h[31:24]};
    w  = {h[7:0], h[15:8], h[23:16], h[31:24]};
    for (int k = 0; k < 8; k++) begin
      if (mode == 2'b00)
        m_dots[k] = {h[31-k], h[23-k], h[15-k], h[7-k]};
      else if (mode == 2'b01)
        m_dots[k] = {hi[15-2*k], hi[14-2*k], lo[15-2*k], lo[14-2*k]};
      else
        m_dots[k] = w[31-4*k -: 4];
    end
    m_len = 8;
    m_dots[8] = 4'h0;
    if (nine && mode == 2'b00) begin
      m_len = 9;
      m_dots[8] = lg ? m_dots[7] : 4'h0;
    end
  endtask

  task automatic model_edge();
    if (!h_reset_n) begin
      m_hold = 32'h0; m_hold_lg = 1'b0; m_len = 0; m_idx = 0;
      m_pix = 4'h0; m_vld = 1'b0;
    end else if (bus.dclk_en) begin
      if (bus.final_sh_ld) begin
        build_char(m_hold, bus.shift_mode, bus.c_9dot, m_hold_lg);
        m_idx = 1; m_pix = m_dots[0]; m_vld = 1'b1;
      end else if (m_idx < m_len) begin
        m_pix = m_dots[m_idx]; m_vld = 1'b1; m_idx++;
      end else begin
        m_pix = 4'h0; m_vld = 1'b0;
      end
      if (bus.screen_off) begin
        m_pix = 4'h0; m_vld = 1'b0;
      end
      if (bus.pre_load) begin
        m_hold    = bus.m_plane_data;
        m_hold_lg = bus.line_gfx_en & bus.c_lg_char;
      end
    end
  endtask

  task automatic tick();
    @(posedge t_crt_clk);
    model_edge();
    #1;
    obs_pix = bus.pix_out;
    obs_vld = bus.pix_vld;
    chk("pix_model", obs_pix, m_pix);
    chk("vld_model", obs_vld, m_vld);
  endtask

  task automatic drive(input logic en, input logic pre, input logic fin, input logic so);
    bus.dclk_en = en; bus.pre_load = pre; bus.final_sh_ld = fin; bus.screen_off = so;
  endtask

  task automatic preload(input logic [31:0] d);
    bus.m_plane_data = d;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic load_char(input logic [1:0] mode);
    bus.shift_mode = mode;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    h_reset_n = 1'b0;
    bus.m_plane_data = 32'h0; bus.c_9dot = 1'b0; bus.line_gfx_en = 1'b0;
    bus.c_lg_char = 1'b0; bus.shift_mode = 2'b00;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("reset_pix", obs_pix, 4'h0);
    chk("reset_vld", obs_vld, 1'b0);
    h_reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_vld", obs_vld, 1'b0);

    // planar A5
    preload(32'h0000_00A5);
    load_char(2'b00);
    chk("planar_d0", obs_pix, exp_planar[0]);
    for (int k = 1; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
      chk("planar_dk", obs_pix, exp_planar[k]);
      chk("planar_vld", obs_vld, 1'b1);
    end
    tick();
    chk("planar_exhaust_vld", obs_vld, 1'b0);
    chk("planar_exhaust_pix", obs_pix, 4'h0);

    // 9-dot line graphics, then non-LG character
    for (int pass = 0; pass < 2; pass++) begin
      bus.c_9dot = 1'b1; bus.line_gfx_en = 1'b1; bus.c_lg_char = (pass == 0);
      preload(32'h0000_0001);
      load_char(2'b00);
      for (int k = 1; k < 9; k++) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
        if (k == 7) chk("nine_d7", obs_pix, 4'h1);
      end
      chk("nine_d8", obs_pix, (pass == 0) ? 4'h1 : 4'h0);
      chk("nine_d8_vld", obs_vld, 1'b1);
      tick();
      chk("nine_exhaust", obs_vld, 1'b0);
    end
    bus.c_9dot = 1'b0; bus.line_gfx_en = 1'b0; bus.c_lg_char = 1'b0;

    // packed and interleaved
    preload(32'h7654_3210);
    load_char(2'b10);
    chk("packed_d0", obs_pix, exp_packed[0]);
    for (int k = 1; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
      chk("packed_dk", obs_pix, exp_packed[k]);
    end
    preload(32'h0000_1BE4);
    load_char(2'b01);
    chk("inter_d0", obs_pix, exp_inter[0]);
    for (int k = 1; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
      chk("inter_dk", obs_pix, exp_inter[k]);
    end

    // simultaneous pre_load + final_sh_ld uses old hold
    preload(32'h0);
    bus.m_plane_data = 32'hFFFF_FFFF; bus.shift_mode = 2'b00;
    drive(1'b1, 1'b1, 1'b1, 1'b0); tick();
    chk("simul_old_pix", obs_pix, 4'h0);
    chk("simul_old_vld", obs_vld, 1'b1);
    for (int k = 1; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    end
    load_char(2'b00);
    chk("simul_new_pix", obs_pix, 4'hF);

    // gaps, screen_off on dot 3, reset on dot 5
    preload(32'h0000_00A5);
    load_char(2'b00);
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("gap_hold_pix", obs_pix, 4'h1);
    chk("gap_hold_vld", obs_vld, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("gap_d1", obs_pix, 4'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("gap_d2", obs_pix, 4'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
    chk("blank_d3_pix", obs_pix, 4'h0);
    chk("blank_d3_vld", obs_vld, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("after_blank_vld", obs_vld, 1'b1);
    h_reset_n = 1'b0; drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("mid_reset_pix", obs_pix, 4'h0);
    chk("mid_reset_vld", obs_vld, 1'b0);
    h_reset_n = 1'b1; drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("post_reset_vld", obs_vld, 1'b0);

    // random strobes, data, modes, gaps, blanking, rare resets
    for (int n = 0; n < 3000; n++) begin
      h_reset_n        = ($urandom_range(0, 299) != 0);
      bus.dclk_en      = ($urandom_range(0, 3) != 0);
      bus.pre_load     = ($urandom_range(0, 7) == 0);
      bus.final_sh_ld  = ($urandom_range(0, 8) == 0);
      bus.screen_off   = ($urandom_range(0, 19) == 0);
      bus.m_plane_data = $urandom;
      bus.c_9dot       = $urandom_range(0, 1);
      bus.line_gfx_en  = $urandom_range(0, 1);
      bus.c_lg_char    = $urandom_range(0, 1);
      bus.shift_mode   = 2'($urandom_range(0, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
